// File: rtl/pll_lock_supervisor.sv
// PLL supervisor: drives the PLL reset, qualifies lock with a debounce window and a timeout,
// releases the downstream domain resets one by one, and restarts the PLL on loss of lock.
module pll_lock_supervisor #(
  parameter int N_CH         = 2,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 20000,
  parameter int LOCK_STABLE  = 200,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic            clki_i,
  input  logic            rst_i,
  input  logic            lock_i,
  input  logic            retry_req_i,
  output logic            pll_rst_o,
  output logic [N_CH-1:0] rst_out_o,
  output logic            ready_o,
  output logic            fault_o,
  output logic [7:0]      lol_cnt_o,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_WAIT    = 3'd1,
    S_STABLE  = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C      = CNT_W'(0);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] REL_END     = CNT_W'(N_CH * STAGGER);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRY);

  logic             sync1_q;
  logic             sync2_q;
  logic             lock_s;
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] pulse_q,   pulse_d;
  logic [CNT_W-1:0] timer_q,   timer_d;
  logic [CNT_W-1:0] stable_q,  stable_d;
  logic [CNT_W-1:0] rel_q,     rel_d;
  logic [7:0]       retry_q,   retry_d;
  logic [7:0]       lol_q,     lol_d;
  logic             pll_rst_q, pll_rst_d;
  logic [N_CH-1:0]  rst_out_q, rst_out_d;
  logic             ready_q,   ready_d;
  logic             fault_q,   fault_d;
  logic [CNT_W-1:0] timer_inc_s;
  logic             timeout_s;
  logic             retry_ok_s;
  logic [7:0]       lol_inc_s;

  assign lock_s      = sync2_q;
  assign timer_inc_s = timer_q + ONE_C;
  assign timeout_s   = (timer_inc_s == TIMEOUT_C);
  assign retry_ok_s  = ((retry_q + 8'd1) < RETRY_MAX);
  assign lol_inc_s   = (lol_q == 8'hFF) ? lol_q : (lol_q + 8'd1);

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clki_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= lock_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and counter logic; the timeout timer spans WAIT and STABLE so chatter cannot reset it.
  always_comb begin
    state_d  = state_q;
    pulse_d  = ZERO_C;
    timer_d  = timer_q;
    stable_d = ZERO_C;
    rel_d    = ZERO_C;
    retry_d  = retry_q;
    lol_d    = lol_q;
    case (state_q)
      S_RESET: begin
        timer_d = ZERO_C;
        if (pulse_q == PULSE_LAST) begin
          state_d = S_WAIT;
        end else begin
          pulse_d = pulse_q + ONE_C;
        end
      end
      S_WAIT: begin
        timer_d = timer_inc_s;
        if (timeout_s) begin
          if (retry_ok_s) begin
            retry_d = retry_q + 8'd1;
            state_d = S_RESET;
          end else begin
            state_d = S_FAULT;
          end
        end else if (lock_s) begin
          state_d = S_STABLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_STABLE: begin
        timer_d = timer_inc_s;
        // Stable completion takes priority over a coincident timeout.
        if (lock_s && (stable_q == STABLE_LAST)) begin
          state_d = S_RELEASE;
        end else if (timeout_s) begin
          if (retry_ok_s) begin
            retry_d = retry_q + 8'd1;
            state_d = S_RESET;
          end else begin
            state_d = S_FAULT;
          end
        end else if (lock_s) begin
          stable_d = stable_q + ONE_C;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RELEASE: begin
        if (!lock_s) begin
          lol_d   = lol_inc_s;
          state_d = S_RESET;
        end else if (rel_q == REL_END) begin
          retry_d = 8'd0;
          state_d = S_RUN;
        end else begin
          rel_d = rel_q + ONE_C;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lol_d   = lol_inc_s;
          state_d = S_RESET;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FAULT: begin
        if (retry_req_i) begin
          retry_d = 8'd0;
          state_d = S_RESET;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // Output values for the state being entered, so every output is a plain register.
  always_comb begin
    pll_rst_d = (state_d == S_RESET) || (state_d == S_FAULT);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
    rst_out_d = {N_CH{1'b1}};
    for (int i = 0; i < N_CH; i++) begin
      if (state_d == S_RELEASE) begin
        rst_out_d[i] = (rel_d < CNT_W'((i + 1) * STAGGER));
      end else begin
        rst_out_d[i] = (state_d != S_RUN);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clki_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_RESET;
      pulse_q   <= ZERO_C;
      timer_q   <= ZERO_C;
      stable_q  <= ZERO_C;
      rel_q     <= ZERO_C;
      retry_q   <= 8'd0;
      lol_q     <= 8'd0;
      pll_rst_q <= 1'b1;
      rst_out_q <= {N_CH{1'b1}};
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      rel_q     <= rel_d;
      retry_q   <= retry_d;
      lol_q     <= lol_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst_o = pll_rst_q;
  assign rst_out_o = rst_out_q;
  assign ready_o   = ready_q;
  assign fault_o   = fault_q;
  assign lol_cnt_o = lol_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: constant-vector table for the clean start,
// hand-written corner sequences, and random lock/retry stimulus against a phase-level model.
module tb_pll_lock_supervisor;

  localparam int N_CH         = 3;
  localparam int RST_PULSE    = 4;
  localparam int LOCK_TIMEOUT = 100;
  localparam int LOCK_STABLE  = 10;
  localparam int STAGGER      = 2;
  localparam int MAX_RETRY    = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lock_i;
  logic        retry_req_i;
  logic        pll_rst_o;
  logic [2:0]  rst_out_o;
  logic        ready_o;
  logic        fault_o;
  logic [7:0]  lol_cnt_o;
  logic [2:0]  state_o;
  logic [16:0] outs_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase number, cycles spent in phase, timeout timer, lock run length, retries, losses.
  int m_phase, m_el, m_tmo, m_cons, m_retry, m_lol;
  logic m_s1, m_s2;

  pll_lock_supervisor #(
    .N_CH(N_CH), .RST_PULSE(RST_PULSE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE(LOCK_STABLE), .STAGGER(STAGGER), .MAX_RETRY(MAX_RETRY), .CNT_W(16)
  ) dut (
    .clki_i(clk), .rst_i(rst_i), .lock_i(lock_i), .retry_req_i(retry_req_i),
    .pll_rst_o(pll_rst_o), .rst_out_o(rst_out_o), .ready_o(ready_o), .fault_o(fault_o),
    .lol_cnt_o(lol_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign outs_s = {pll_rst_o, rst_out_o, ready_o, fault_o, lol_cnt_o, state_o};

  function automatic logic [16:0] vec(input logic p, input logic [2:0] r, input logic rd,
                                      input logic f, input logic [7:0] l, input logic [2:0] s);
    return {p, r, rd, f, l, s};
  endfunction

  localparam logic [16:0] RST_VEC = {1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 3'd0};

  task automatic check(input string nm, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got pll_rst=%b rst_out=%b ready=%b fault=%b lol=%0d state=%0d, expected pll_rst=%b rst_out=%b ready=%b fault=%b lol=%0d state=%0d",
               nm, got[16], got[15:13], got[12], got[11], got[10:3], got[2:0],
               exp[16], exp[15:13], exp[12], exp[11], exp[10:3], exp[2:0]);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_el = 0; m_tmo = 0; m_cons = 0; m_retry = 0; m_lol = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  function automatic logic [16:0] model_exp();
    logic [2:0] r;
    for (int i = 0; i < N_CH; i++)
      r[i] = !(m_phase == 4 || (m_phase == 3 && m_el >= (i + 1) * STAGGER));
    return {(m_phase == 0 || m_phase == 5), r, (m_phase == 4), (m_phase == 5),
            8'(m_lol), 3'(m_phase)};
  endfunction

  task automatic model_step();
    logic ls;
    if (rst_i) begin
      model_reset();
      return;
    end
    ls = m_s2; m_s2 = m_s1; m_s1 = lock_i;
    case (m_phase)
      0: begin
        if (m_el + 1 == RST_PULSE) begin m_phase = 1; m_el = 0; m_tmo = 0; end
        else m_el++;
      end
      1, 2: begin
        m_tmo++;
        if (m_phase == 2 && ls && m_cons + 1 == LOCK_STABLE) begin
          m_phase = 3; m_el = 0;
        end else if (m_tmo == LOCK_TIMEOUT) begin
          if (m_retry + 1 < MAX_RETRY) begin m_retry++; m_phase = 0; m_el = 0; end
          else m_phase = 5;
        end else if (m_phase == 1) begin
          if (ls) begin m_phase = 2; m_cons = 0; end
        end else if (ls) begin
          m_cons++;
        end else begin
          m_phase = 1;
        end
      end
      3, 4: begin
        if (!ls) begin
          m_phase = 0; m_el = 0;
          if (m_lol < 255) m_lol++;
        end else if (m_phase == 3) begin
          if (m_el == N_CH * STAGGER) begin m_phase = 4; m_retry = 0; end
          else m_el++;
        end
      end
      5: if (retry_req_i) begin m_phase = 0; m_el = 0; m_retry = 0; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", outs_s, model_exp());
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    check("async_rst", outs_s, RST_VEC);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_cyc);
    int n = 0;
    while (state_o !== st && n < max_cyc) begin
      tick();
      n++;
    end
    if (state_o !== st) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_state: state=%0d expected=%0d within %0d cycles", state_o, st, max_cyc);
    end
  endtask

  typedef struct {
    string       name;
    logic        lock;
    int          cycles;
    logic [16:0] exp;
  } row_t;

  row_t tbl[12];

  task automatic set_row(input int idx, input string nm, input logic lk, input int cyc,
                         input logic [16:0] e);
    tbl[idx].name = nm; tbl[idx].lock = lk; tbl[idx].cycles = cyc; tbl[idx].exp = e;
  endtask

  initial begin
    bit saw_release;
    rst_i = 1'b0; lock_i = 1'b1; retry_req_i = 1'b0;

    // Clean start: 4 reset + 1 wait + 10 stable + 7 release = READY on edge 22.
    set_row(0,  "rst_val",  1'b1, 0, RST_VEC);
    set_row(1,  "pulse3",   1'b1, 3, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 3'd0));
    set_row(2,  "wait",     1'b1, 1, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 3'd1));
    set_row(3,  "stable",   1'b1, 1, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 3'd2));
    set_row(4,  "stable9",  1'b1, 9, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 3'd2));
    set_row(5,  "rel_in",   1'b1, 1, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 3'd3));
    set_row(6,  "rel1",     1'b1, 1, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 3'd3));
    set_row(7,  "ch0_rel",  1'b1, 1, vec(1'b0, 3'b110, 1'b0, 1'b0, 8'd0, 3'd3));
    set_row(8,  "ch1_rel",  1'b1, 2, vec(1'b0, 3'b100, 1'b0, 1'b0, 8'd0, 3'd3));
    set_row(9,  "ch2_rel",  1'b1, 2, vec(1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 3'd3));
    set_row(10, "ready",    1'b1, 1, vec(1'b0, 3'b000, 1'b1, 1'b0, 8'd0, 3'd4));
    set_row(11, "run_hold", 1'b1, 5, vec(1'b0, 3'b000, 1'b1, 1'b0, 8'd0, 3'd4));

    #2;
    do_reset();
    for (int r = 0; r < 12; r++) begin
      lock_i = tbl[r].lock;
      for (int c = 0; c < tbl[r].cycles; c++) tick();
      check(tbl[r].name, outs_s, tbl[r].exp);
    end

    // Loss of lock in RUN: one-cycle drop reaches outputs on the third edge.
    lock_i = 1'b0; tick();
    lock_i = 1'b1; tick(); tick();
    check("lol_run", outs_s, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd1, 3'd0));
    repeat (3) tick();
    check("lol_pulse_hi", outs_s, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd1, 3'd0));
    tick();
    check("lol_pulse_end", outs_s, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd1, 3'd1));
    wait_state(3'd4, 60);
    check("lol_ready", outs_s, vec(1'b0, 3'b000, 1'b1, 1'b0, 8'd1, 3'd4));

    // Chatter: two timeouts exhaust the retry budget.
    do_reset();
    saw_release = 1'b0;
    for (int c = 0; c < 230; c++) begin
      if (c % 5 == 0) lock_i = ~lock_i;
      tick();
      if (state_o == 3'd3) saw_release = 1'b1;
    end
    n_checks++;
    if (saw_release) begin
      n_fail++;
      $display("FAIL chatter_no_release: release entered=%b required=0", saw_release);
    end
    check("chatter_fault", outs_s, vec(1'b1, 3'b111, 1'b0, 1'b1, 8'd0, 3'd5));

    // Fault recovery via RETRY_REQ.
    lock_i = 1'b1; retry_req_i = 1'b1; tick();
    retry_req_i = 1'b0;
    check("fault_clr", outs_s, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 3'd0));
    wait_state(3'd4, 60);
    check("recover_ready", outs_s, vec(1'b0, 3'b000, 1'b1, 1'b0, 8'd0, 3'd4));

    // Loss of lock in RELEASE leaves the retry count untouched.
    do_reset();
    lock_i = 1'b1;
    wait_state(3'd3, 40);
    tick(); tick();
    check("rel_ch0_low", outs_s, vec(1'b0, 3'b110, 1'b0, 1'b0, 8'd0, 3'd3));
    lock_i = 1'b0;
    repeat (3) tick();
    check("lol_release", outs_s, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd1, 3'd0));
    repeat (115) tick();
    check("one_timeout_no_fault", outs_s, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd1, 3'd1));

    // Async reset during STABLE.
    do_reset();
    lock_i = 1'b1;
    wait_state(3'd2, 20);
    tick();
    do_reset();

    // Async reset with LOL_CNT=5.
    for (int k = 0; k < 5; k++) begin
      wait_state(3'd4, 60);
      lock_i = 1'b0; tick();
      lock_i = 1'b1; tick(); tick();
    end
    check("lol5", outs_s, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd5, 3'd0));
    do_reset();

    // Random lock segments and retry pulses against the model.
    for (int s = 0; s < 150; s++) begin
      int len;
      len = $urandom_range(1, 40);
      lock_i = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < len; c++) begin
        retry_req_i = ($urandom_range(0, 19) == 0);
        tick();
      end
      retry_req_i = 1'b0;
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised PLL supervisor for the clock-generation subsystem. Runs on the PLL reference clock, drives the PLL reset input, and qualifies the PLL lock output with a debounce window and a lock timeout. Releases N downstream per-domain resets in a staggered sequence, and retries the PLL a bounded number of times before latching a fault. On loss of lock it re-asserts all domain resets and restarts the PLL, which the bare PLL instance does not do.

## Interface
- N_CH, 2: number of downstream reset channels (1..8)
- RST_PULSE, 16: PLL reset pulse length, CLKI cycles (≥1)
- LOCK_TIMEOUT, 20000: max cycles from PLL_RST deassertion to qualified lock (1 ms at 20 MHz)
- LOCK_STABLE, 200: consecutive cycles synchronised lock must stay high
- STAGGER, 8: cycles between successive channel releases (≥1)
- MAX_RETRY, 3: lock timeouts tolerated before FAULT (≥1)
- CNT_W, 16: width of internal timers; must hold LOCK_TIMEOUT
- CLKI  in  1  reference clock; the only clock.
- RST  in  1  asynchronous, active-high reset.
- LOCK  in  1  raw PLL lock, asynchronous; 2-FF synchronised internally (lock_s).
- RETRY_REQ  in  1  single-cycle pulse; leaves FAULT, ignored in other states.
- PLL_RST  out  1  to PLL RST input.
- RST_OUT  out  N_CH  per-domain reset, active-high.
- READY  out  1  all channels released, PLL qualified.
- FAULT  out  1  retry budget exhausted.
- LOL_CNT  out  8  loss-of-lock events after release began; saturates at 255.
- STATE  out  3  encoded FSM state, for debug.

## Operation
- Reset values: PLL_RST=1, RST_OUT=all ones, READY=0, FAULT=0, LOL_CNT=0, STATE=S_RESET(0). The retry counter and timers are also 0.
- S_RESET(0): PLL_RST=1 for exactly RST_PULSE cycles, then go to S_WAIT. The timeout timer is cleared on exit.
- S_WAIT(1): PLL_RST=0. If lock_s=1, go to S_STABLE. The timeout timer increments every cycle in S_WAIT and S_STABLE and is not cleared between them, so a chattering lock cannot evade the timeout.
- S_STABLE(2): the stable counter counts consecutive lock_s=1 cycles. When LOCK_STABLE is reached, go to S_RELEASE. If lock_s=0, clear the stable counter and return to S_WAIT.
- Timeout: the timer reaches LOCK_TIMEOUT while in S_WAIT or S_STABLE.
  - If retry+1 < MAX_RETRY: increment retry, go to S_RESET.
  - Otherwise: go to S_FAULT.
  - If the stable-count completion and the timeout occur in the same cycle, the stable completion wins.
- S_RELEASE(3): RST_OUT[i] deasserts k·STAGGER cycles after entry, where k=i+1. Channel 0 releases first. One cycle after RST_OUT[N_CH-1] falls, go to S_RUN with READY=1. Retry is cleared on entering S_RUN.
- S_RUN(4): hold all outputs. If lock_s=0, go to S_RESET (loss of lock).
- Loss of lock in S_RELEASE or S_RUN:
  - RST_OUT goes to all ones and READY goes to 0 on the next edge.
  - LOL_CNT increments, saturating.
  - Retry is not incremented.
- S_FAULT(5): PLL_RST=1, RST_OUT=all ones, FAULT=1. Exits only on RETRY_REQ=1, which clears retry and FAULT and goes to S_RESET.
- Async RST mid-operation: all outputs return to their reset values immediately, including LOL_CNT.
- Unused STATE encodings (6, 7) go to S_RESET.

## Timing
- All outputs are registered. Each output changes on the CLKI edge that enters the state driving it.
- LOCK to lock_s: 2-cycle synchroniser latency. A lock drop therefore reaches RST_OUT in 3 edges (2 sync + 1 register).
- Minimum time from RST release to READY, with LOCK high throughout:
  - RST_PULSE cycles in S_RESET.
  - +1 cycle (S_WAIT).
  - +LOCK_STABLE cycles in S_STABLE.
  - +N_CH·STAGGER+1 cycles in S_RELEASE.
- Timers are CNT_W bits. Comparisons are equality against the parameter value, with no wrap-around.

## Test plan
Bench parameters: N_CH=3, RST_PULSE=4, LOCK_TIMEOUT=100, LOCK_STABLE=10, STAGGER=2, MAX_RETRY=2.

- **Clean start:** LOCK=1 constantly, then release RST.
  - PLL_RST is high for 4 cycles.
  - RST_OUT[0], [1], [2] fall 2, 4 and 6 cycles after S_RELEASE entry.
  - READY rises 7 cycles after S_RELEASE entry.
  - Total: READY rises 4+1+10+7=22 edges after RST release. FAULT=0, LOL_CNT=0.
- **Chatter:** LOCK toggles every 5 cycles.
  - S_STABLE never completes; S_RELEASE is never entered.
  - Timeout at 100 cycles → retry=1, PLL_RST pulses again.
  - Second timeout → FAULT=1, PLL_RST=1, RST_OUT=3'b111.
- **Fault recovery:** from FAULT, set LOCK=1 and pulse RETRY_REQ.
  - FAULT clears on the next edge.
  - The clean-start sequence follows and READY=1.
- **Loss of lock in S_RUN:** drop LOCK for 1 cycle.
  - RST_OUT=3'b111 and READY=0 within 3 edges.
  - LOL_CNT=1; PLL_RST high for 4 cycles.
  - The full sequence repeats and READY returns.
- **Loss of lock in S_RELEASE:** drop LOCK after RST_OUT[0] has fallen.
  - All channels re-assert and LOL_CNT increments.
  - Retry is unchanged, shown by FAULT staying 0 after a subsequent single timeout.
- **Async reset mid-sequence:** assert RST during S_STABLE, and separately with LOL_CNT=5.
  - All outputs take their reset values without waiting for a CLKI edge, including LOL_CNT=0.
